// File: rtl/led_scan_sequencer_pkg.sv
// led_scan_pkg: scan FSM states and default panel timing
// shared by the LED scan sequencer and its interface.
package led_scan_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    BLANK,
    DISPLAY
  } state_t;

  localparam int DEF_NUM_ROWS     = 16;
  localparam int DEF_PWM_BITS     = 8;
  localparam int DEF_SHIFT_LEN    = 32;
  localparam int DEF_BLANK_CYCLES = 4;
  localparam int DEF_BCM_UNIT     = 8;

endpackage

// File: rtl/led_scan_sequencer_if.sv
// led_scan_sequencer_if: host control, swap handshake and
// panel driver strobes of the LED scan sequencer.
interface led_scan_sequencer_if
  import led_scan_pkg::*;
#(
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int PWM_BITS = DEF_PWM_BITS
);

  localparam int ROW_BITS = $clog2(NUM_ROWS);

  logic                scan_enable;
  logic                swap_req;
  logic                swap_ack;
  logic                buffer_sel;
  logic                frame_start;
  logic                load;
  logic                shift;
  logic [PWM_BITS-1:0] pwm_time;
  logic [ROW_BITS-1:0] active_row_addr;
  logic                serial_clk;
  logic                latch_enable;
  logic                output_enable_n;
  logic [NUM_ROWS-1:0] row_select_n;

  modport master (
    input  scan_enable, swap_req,
    output swap_ack, buffer_sel, frame_start,
    output load, shift, pwm_time,
    output active_row_addr, serial_clk,
    output latch_enable, output_enable_n,
    output row_select_n
  );

  modport slave (
    output scan_enable, swap_req,
    input  swap_ack, buffer_sel, frame_start,
    input  load, shift, pwm_time,
    input  active_row_addr, serial_clk,
    input  latch_enable, output_enable_n,
    input  row_select_n
  );

endinterface

// File: rtl/led_scan_sequencer_decoder.sv
// inverting_decoder: binary address to one-hot-low select.
// Used for the active-low row drive of the LED panel.
module inverting_decoder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]      addr,
  output logic [2**WIDTH-1:0]   sel_n
);

  always_comb begin
    sel_n = '1;
    for (int i = 0; i < 2**WIDTH; i++) begin
      sel_n[i] = (addr != WIDTH'(i));
    end
  end

endmodule

// File: rtl/led_scan_sequencer.sv
// led_scan_sequencer: row/PWM scan engine for multiplexed LED panels.
// Define LED_BCM_EN for binary-coded modulation with a DISPLAY phase.
module led_scan_sequencer
  import led_scan_pkg::*;
#(
  parameter int NUM_ROWS     = DEF_NUM_ROWS,
  parameter int PWM_BITS     = DEF_PWM_BITS,
  parameter int SHIFT_LEN    = DEF_SHIFT_LEN,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int BCM_UNIT     = DEF_BCM_UNIT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  led_scan_sequencer_if.master bus
);

  localparam int ROW_BITS = $clog2(NUM_ROWS);

`ifdef LED_BCM_EN
  localparam bit BCM   = 1'b1;
  localparam int STEPS = PWM_BITS;
`else
  localparam bit BCM   = 1'b0;
  localparam int STEPS = 2 ** PWM_BITS;
`endif

  localparam logic [PWM_BITS-1:0] PWM_LAST =
    PWM_BITS'(STEPS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST =
    ROW_BITS'(NUM_ROWS - 1);
  localparam logic [31:0] SHIFT_END =
    32'(2 * SHIFT_LEN - 1);
  localparam logic [31:0] BLANK_END =
    32'(BLANK_CYCLES - 1);

  state_t              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_nx, plane_q;
  logic [ROW_BITS-1:0] row_q, row_nx, disp_row_q;
  logic                first_q, row_on_q;
  logic                buf_q, ack_q;
  logic                step_last, frame_end;
  logic                disp_end;
  logic [2**ROW_BITS-1:0] dec_n;

  assign step_last = (pwm_q == PWM_LAST);
  assign frame_end = step_last && (row_q == ROW_LAST);
  assign pwm_nx    = step_last ? '0 : pwm_q + 1'b1;
  assign row_nx    = (row_q == ROW_LAST) ? '0
                   : row_q + 1'b1;
  assign disp_end  =
    (cnt_q == ((32'(BCM_UNIT) << plane_q) - 32'd1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.scan_enable) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == SHIFT_END) begin
          cnt_d   = '0;
          state_d = LATCH;
        end
      end
      LATCH: begin
        cnt_d = '0;
        if (!bus.scan_enable)
          state_d = IDLE;
        else if (step_last || first_q)
          state_d = BLANK;
        else if (BCM)
          state_d = DISPLAY;
        else
          state_d = LOAD;
      end
      BLANK: begin
        if (cnt_q == BLANK_END) begin
          cnt_d   = '0;
          state_d = BCM ? DISPLAY : LOAD;
        end
      end
      DISPLAY: begin
        if (disp_end) begin
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pwm_q      <= '0;
      plane_q    <= '0;
      row_q      <= '0;
      disp_row_q <= '0;
      first_q    <= 1'b1;
      row_on_q   <= 1'b0;
      buf_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= 1'b0;
      if (state_q == IDLE) first_q <= 1'b1;
      // a step is complete once latched, even when stopping
      if (state_q == LATCH) begin
        first_q <= 1'b0;
        plane_q <= pwm_q;
        pwm_q   <= pwm_nx;
        if (step_last) row_q <= row_nx;
        if (frame_end && bus.swap_req) begin
          buf_q <= ~buf_q;
          ack_q <= 1'b1;
        end
      end
      if (state_q == LATCH && state_d == BLANK) begin
        row_on_q   <= 1'b1;
        disp_row_q <= step_last ? row_nx : row_q;
      end
      if (state_d == IDLE) row_on_q <= 1'b0;
    end
  end

  inverting_decoder #(.WIDTH(ROW_BITS)) u_dec (
    .addr  (disp_row_q),
    .sel_n (dec_n)
  );

  assign bus.load         = (state_q == LOAD);
  assign bus.shift        = (state_q == SHIFT) & ~cnt_q[0];
  assign bus.serial_clk   = (state_q == SHIFT) & cnt_q[0];
  assign bus.latch_enable = (state_q == LATCH);
  assign bus.output_enable_n = BCM
    ? (state_q != DISPLAY)
    : !(state_q == LOAD || state_q == SHIFT);
  assign bus.frame_start  = (state_q == LOAD)
                          && (row_q == '0)
                          && (pwm_q == '0);
  assign bus.pwm_time        = pwm_q;
  assign bus.active_row_addr = row_q;
  assign bus.buffer_sel      = buf_q;
  assign bus.swap_ack        = ack_q;
  assign bus.row_select_n    =
    row_on_q ? dec_n[NUM_ROWS-1:0] : '1;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// tb_led_scan_sequencer: random scan_enable/swap_req stimulus checked
// cycle by cycle against a step-timeline reference model.
module tb_led_scan_sequencer;

  localparam int NR = 4;
  localparam int PB = 3;
  localparam int SL = 5;
  localparam int BC = 3;
  localparam int BU = 2;
  localparam int RB = 2;

`ifdef LED_BCM_EN
  localparam bit BCM   = 1'b1;
  localparam int STEPS = PB;
`else
  localparam bit BCM   = 1'b0;
  localparam int STEPS = 1 << PB;
`endif

  typedef struct packed {
    logic          load;
    logic          shift;
    logic          sclk;
    logic          le;
    logic          oe_n;
    logic [NR-1:0] rsn;
    logic [PB-1:0] pwm;
    logic [RB-1:0] row;
    logic          fs;
    logic          bsel;
    logic          ack;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  led_scan_sequencer_if #(
    .NUM_ROWS(NR), .PWM_BITS(PB)
  ) bus ();

  led_scan_sequencer #(
    .NUM_ROWS(NR), .PWM_BITS(PB), .SHIFT_LEN(SL),
    .BLANK_CYCLES(BC), .BCM_UNIT(BU)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  obs_t          q[$];
  int            m_row, m_pwm, nshift;
  bit            m_buf, m_first, ack_next;
  logic [NR-1:0] shown;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h",
               tag, $time, got, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t r;
    r.load  = bus.load;
    r.shift = bus.shift;
    r.sclk  = bus.serial_clk;
    r.le    = bus.latch_enable;
    r.oe_n  = bus.output_enable_n;
    r.rsn   = bus.row_select_n;
    r.pwm   = bus.pwm_time;
    r.row   = bus.active_row_addr;
    r.fs    = bus.frame_start;
    r.bsel  = bus.buffer_sel;
    r.ack   = bus.swap_ack;
    return r;
  endfunction

  function automatic obs_t rst_rec();
    obs_t r = '0;
    r.oe_n = 1'b1;
    r.rsn  = '1;
    return r;
  endfunction

  task automatic push_rec(obs_t r);
    r.pwm  = PB'(m_pwm);
    r.row  = RB'(m_row);
    r.bsel = m_buf;
    r.ack  = ack_next;
    ack_next = 1'b0;
    q.push_back(r);
  endtask

  task automatic push_idle();
    obs_t r = '0;
    r.oe_n = 1'b1;
    r.rsn  = '1;
    push_rec(r);
  endtask

  // one step: LOAD, SL two-cycle shift bits, LATCH
  task automatic push_step();
    obs_t r;
    for (int i = 0; i <= 2 * SL + 1; i++) begin
      r      = '0;
      r.load = (i == 0);
      if (i >= 1 && i <= 2 * SL) begin
        r.shift = (i % 2 == 1);
        r.sclk  = (i % 2 == 0);
      end
      r.le   = (i == 2 * SL + 1);
      r.oe_n = BCM ? 1'b1 : r.le;
      r.rsn  = shown;
      r.fs   = (i == 0) && (m_row == 0) && (m_pwm == 0);
      push_rec(r);
    end
  endtask

  task automatic advance();
    obs_t r;
    int   plane = m_pwm;
    bit   wrap  = 1'b0;
    if (m_row == NR - 1 && m_pwm == STEPS - 1
        && bus.swap_req) begin
      m_buf    = !m_buf;
      ack_next = 1'b1;
    end
    if (m_pwm == STEPS - 1) begin
      m_pwm = 0;
      m_row = (m_row + 1) % NR;
      wrap  = 1'b1;
    end else begin
      m_pwm++;
    end
    if (!bus.scan_enable) begin
      m_first = 1'b1;
      shown   = '1;
      push_idle();
      return;
    end
    if (wrap || m_first) begin
      shown   = ~(NR'(1) << m_row);
      m_first = 1'b0;
      for (int i = 0; i < BC; i++) begin
        r      = '0;
        r.oe_n = 1'b1;
        r.rsn  = shown;
        push_rec(r);
      end
    end
    if (BCM) begin
      for (int i = 0; i < (BU << plane); i++) begin
        r     = '0;
        r.rsn = shown;
        push_rec(r);
      end
    end
    push_step();
  endtask

  task automatic model_reset();
    q.delete();
    m_row    = 0;
    m_pwm    = 0;
    m_buf    = 1'b0;
    m_first  = 1'b1;
    ack_next = 1'b0;
    shown    = '1;
    nshift   = 0;
    push_idle();
  endtask

  task automatic run(int n, bit quiet);
    obs_t e, g;
    repeat (n) begin
      @(negedge clk);
      e = q.pop_front();
      g = sample();
      chk("cycle", 64'(g), 64'(e));
      if (g.load) nshift = 0;
      if (g.shift) nshift++;
      if (g.le) chk("shift_cnt", 64'(nshift), 64'(SL));
      if (quiet)
        bus.scan_enable = 1'b0;
      else if (bus.scan_enable)
        bus.scan_enable = ($urandom_range(299) != 0);
      else
        bus.scan_enable = ($urandom_range(7) == 0);
      if ($urandom_range(149) == 0)
        bus.swap_req = ~bus.swap_req;
      if (q.size() == 0) begin
        if (e.le) advance();
        else if (bus.scan_enable) push_step();
        else push_idle();
      end
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.scan_enable = 1'b0;
    bus.swap_req    = 1'b0;
    #2;
    chk("reset", 64'(sample()), 64'(rst_rec()));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    run(100, 1'b1);
    run(3500, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", 64'(sample()), 64'(rst_rec()));
    model_reset();
    bus.scan_enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run(2000, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
